// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential 32x32 signed multiplier among NREQ
// requesters.
//
// A round-robin arbiter grants one requester at a time. The grant is the
// accept of a valid/ready handshake. The block then starts the multiplier
// (ena+rst strobe), waits for dne or a timeout, and presents the product
// with the owner's id until the consumer takes it.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake, ready is one-hot
//   req_a/req_b         operands of requester i at [32*i +: 32]
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_p/rsp_err owner, 64-bit product, timeout flag
//   mul_a/mul_b         registered operands to the multiplier
//   mul_ena/mul_rst     multiplier enable / start strobe
//   mul_p/mul_dne       multiplier product / done
module mul_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 48,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_p,
  output logic                 rsp_err,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_ena,
  output logic                 mul_rst,
  input  logic [63:0]          mul_p,
  input  logic                 mul_dne
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t         state, nxt;
  logic [IDW-1:0] last;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] gnt;
  logic           gnt_vld;

  // Requester index 'off' positions after 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(logic [IDW-1:0] base, int off);
    int s;
    s = int'(base) + off;
    return IDW'(s % NREQ);
  endfunction

  // Search starts just after the last winner, so the last winner ranks lowest.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!gnt_vld && req_valid[rr_idx(last, i)]) begin
        gnt_vld = 1'b1;
        gnt     = rr_idx(last, i);
      end
    end
  end

  wire timed_out = (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (gnt_vld) nxt = S_LAUNCH;
      S_LAUNCH: nxt = S_WAIT;
      S_WAIT:   if (mul_dne || timed_out) nxt = S_RESP;
      S_RESP:   if (rsp_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs. Handshake and multiplier controls are masked during reset so
  // nothing is accepted or started while the state is still unknown.
  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && gnt_vld) req_ready[gnt] = 1'b1;
    mul_ena   = !rst && (state == S_LAUNCH || state == S_WAIT);
    mul_rst   = !rst && (state == S_LAUNCH);
    rsp_valid = (state == S_RESP);
  end

  // Datapath. WAIT is entered only through LAUNCH, and LAUNCH restarts the
  // multiplier. A dne left over from the previous op is therefore cleared
  // before WAIT samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= IDW'(NREQ - 1);
      mul_a   <= '0;
      mul_b   <= '0;
      rsp_id  <= '0;
      rsp_p   <= '0;
      rsp_err <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          mul_a  <= req_a[32*gnt +: 32];
          mul_b  <= req_b[32*gnt +: 32];
          rsp_id <= gnt;
          last   <= gnt;
        end
        S_LAUNCH: cnt <= '0;
        S_WAIT: begin
          if (mul_dne) begin
            rsp_p   <= mul_p;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_p   <= '0;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter. It contains a stub sequential multiplier that
// takes k+1 enabled cycles after the start strobe, where k is the bit length
// of |a|. A transaction-level model predicts the grant, the response timing
// and the response contents.
module tb_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 48;
  localparam int IDW     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*32-1:0]  req_a = '0, req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid, rsp_err;
  logic                rsp_ready = 1'b1;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_p, mul_p;
  logic [31:0]         mul_a, mul_b;
  logic                mul_ena, mul_rst, mul_dne;

  mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_err(rsp_err), .mul_a(mul_a),
    .mul_b(mul_b), .mul_ena(mul_ena), .mul_rst(mul_rst), .mul_p(mul_p),
    .mul_dne(mul_dne));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int kpos(logic [31:0] a, logic [31:0] b);
    logic [32:0] m;
    int r;
    r = 0;
    if (a == 0 || b == 0) return 0;
    m = a[31] ? (33'd0 - {a[31], a}) : {1'b0, a};
    for (int i = 0; i < 33; i++) if (m[i]) r = i + 1;
    return r;
  endfunction

  function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b);
    logic signed [63:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // Stub multiplier: never reset; the start strobe reloads it.
  logic        stuck = 1'b0;
  logic [63:0] sp = '0;
  logic        sdne = 1'b0;
  int          rem = 0;
  always @(posedge clk) begin
    if (mul_ena) begin
      if (mul_rst) begin
        rem  <= kpos(mul_a, mul_b) + 1;
        sdne <= 1'b0;
        sp   <= prod(mul_a, mul_b);
      end else if (rem != 0) begin
        rem <= rem - 1;
        if (rem == 1 && !stuck) sdne <= 1'b1;
      end
    end
  end
  assign mul_p   = sp;
  assign mul_dne = sdne;

  // Transaction model: one op in flight. Cycle offsets from the grant:
  // start strobe at +1, response at +4+k, timeout response at +TIMEOUT+2.
  int              cyc = 0, m_gcyc = 0, m_due = 0, m_id = 0, m_last = NREQ - 1;
  logic            m_busy = 1'b0, m_err = 1'b0, chk_reset = 1'b0, prev_v = 1'b0;
  logic [63:0]     m_p = '0;
  logic [31:0]     m_a = '0, m_b = '0;
  logic [NREQ-1:0] gnt_seen = '0;
  int              n_rsp = 0, rise_lat = 0;
  logic [63:0]     seen_p = '0;
  int              seen_id = 0;
  logic            seen_err = 1'b0;
  int              grant_log[$];

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int   gi;
    logic exp_v;
    cyc++;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_ena", mul_ena, 0);
      chk("rst_mrst", mul_rst, 0);
      m_busy = 1'b0; m_last = NREQ - 1; chk_reset = 1'b1; prev_v = 1'b0;
      gnt_seen = '0;
      grant_log.delete();
    end else begin
      if (chk_reset) begin
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_p", rsp_p, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_mul_ab", {mul_a, mul_b}, 0);
        chk_reset = 1'b0;
      end
      exp_ready = '0;
      gi = 0;
      if (!m_busy)
        for (int j = 1; j <= NREQ; j++)
          if (exp_ready == 0 && req_valid[(m_last + j) % NREQ]) begin
            gi = (m_last + j) % NREQ;
            exp_ready[gi] = 1'b1;
          end
      chk("req_ready", req_ready, exp_ready);
      chk("ready_onehot", $onehot0(req_ready), 1);
      exp_v = m_busy && cyc >= m_due;
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v && rsp_valid) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_p", rsp_p, m_p);
        chk("rsp_err", rsp_err, m_err);
      end
      chk("mul_rst", mul_rst, m_busy && cyc == m_gcyc + 1);
      chk("mul_ena", mul_ena, m_busy && cyc > m_gcyc && cyc < m_due);
      if (m_busy && cyc == m_gcyc + 1) chk("mul_ab", {mul_a, mul_b}, {m_a, m_b});
      if (rsp_valid && !prev_v) rise_lat = cyc - m_gcyc;
      prev_v   = rsp_valid;
      gnt_seen = req_ready;
      if (exp_ready != 0) begin
        m_busy = 1'b1; m_last = gi; m_gcyc = cyc; m_id = gi;
        m_a = req_a[32*gi +: 32];
        m_b = req_b[32*gi +: 32];
        m_err = stuck;
        m_p   = stuck ? 64'd0 : prod(m_a, m_b);
        m_due = cyc + (stuck ? TIMEOUT + 2 : 4 + kpos(m_a, m_b));
        grant_log.push_back(gi);
      end else if (exp_v && rsp_ready) begin
        m_busy = 1'b0;
        n_rsp++;
        seen_p = rsp_p; seen_id = int'(rsp_id); seen_err = rsp_err;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_until_grant(input int i);
    for (int n = 0; n < 200; n++) begin
      step();
      if (gnt_seen[i]) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    chk("grant_wait", 0, 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
    hold_until_grant(i);
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = n_rsp;
    issue(i, a, b);
    for (int n = 0; n < 200 && n_rsp == n0; n++) step();
    if (n_rsp == n0) chk("rsp_wait", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    int sz;
    do_reset();
    // Directed: basic products and latency.
    run_op(0, 32'd3, 32'd5);
    chk("t1_p", seen_p, 64'd15);
    chk("t1_id", seen_id, 0);
    chk("t1_err", seen_err, 0);
    chk("t1_lat", rise_lat, 6);
    run_op(1, -32'sd3, 32'd5);
    chk("t2_p", seen_p, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t2_id", seen_id, 1);
    run_op(1, 32'h8000_0000, 32'h8000_0000);
    chk("t2b_p", seen_p, 64'h4000_0000_0000_0000);
    chk("t2b_lat", rise_lat, 36);
    run_op(3, 32'h0, 32'h1234);
    chk("t2c_lat", rise_lat, 4);

    // All requesters valid from reset: strict rotation.
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = rnd_op();
      req_b[32*i +: 32] = rnd_op();
    end
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 400 && grant_log.size() < 5; n++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (gnt_seen[i]) begin
          req_a[32*i +: 32] = rnd_op();
          req_b[32*i +: 32] = rnd_op();
        end
    end
    req_valid = '0;
    chk("rr_count", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      chk("rr_0", grant_log[0], 0);
      chk("rr_1", grant_log[1], 1);
      chk("rr_2", grant_log[2], 2);
      chk("rr_3", grant_log[3], 3);
      chk("rr_4", grant_log[4], 0);
    end
    for (int n = 0; n < 200 && m_busy; n++) step();

    // Response stall: result held, no new grant while waiting.
    rsp_ready = 1'b0;
    issue(1, 32'd100, -32'sd7);
    req_a[64 +: 32] = 32'd11;
    req_b[64 +: 32] = 32'd13;
    req_valid[2] = 1'b1;
    for (int n = 0; n < 100 && !rsp_valid; n++) step();
    sz = grant_log.size();
    repeat (10) step();
    chk("stall_valid", rsp_valid, 1);
    chk("stall_p", rsp_p, 64'hFFFF_FFFF_FFFF_FD44);
    chk("stall_nogrant", grant_log.size(), sz);
    rsp_ready = 1'b1;
    hold_until_grant(2);
    for (int n = 0; n < 100 && m_busy; n++) step();
    chk("stall_next_p", seen_p, 64'd143);

    // Multiplier never finishes: timeout, then normal service resumes.
    stuck = 1'b1;
    run_op(3, 32'd5, 32'd9);
    chk("to_err", seen_err, 1);
    chk("to_p", seen_p, 0);
    chk("to_lat", rise_lat, TIMEOUT + 2);
    stuck = 1'b0;
    run_op(3, 32'd5, 32'd9);
    chk("to_next_p", seen_p, 64'd45);
    chk("to_next_err", seen_err, 0);

    // Reset mid-wait: op dropped, later op unaffected.
    issue(0, 32'h7FFF_FFFF, 32'd3);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_op(2, 32'd7, 32'd6);
    chk("rw_p", seen_p, 64'd42);
    chk("rw_id", seen_id, 2);
    chk("rw_lat", rise_lat, 7);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_seen[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[32*i +: 32] = rnd_op();
          req_b[32*i +: 32] = rnd_op();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (100) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
